// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display path: the scan mux and the
// bin_7seg wrapper agree on nibble width, the blank nibble and the anode-off pattern.
package calc_disp_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 64;

    // Wide enough for any supported bank; users slice [NUM_DIGITS-1:0].
    localparam logic [MAX_DIGITS-1:0] AN_OFF       = '1;
    localparam logic [NIBBLE_W-1:0]   BLANK_NIBBLE = 4'h0;

endpackage

// File: rtl/seg_scan_mux_clk_tick_div.sv
// Refresh prescaler: free-running 0..DIV-1 counter with a 1-cycle tick on the
// last count. DIV = 1 ticks every cycle.
module clk_tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int               DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan controller: double-buffered hex value, one
// nibble per scan slot, active-low anodes, leading-zero blanking, frame pulse.
module seg_scan_mux
    import calc_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           LOAD,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] VALUE,
    input  logic                           BLANK_LZ,
    output logic [NIBBLE_W-1:0]            BI_DIGIT,
    output logic                           DIG_BLANK,
    output logic [NUM_DIGITS-1:0]          AN,
    output logic                           FRAME
);

    localparam int                SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                VAL_W     = NIBBLE_W * NUM_DIGITS;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    logic                  tick, boundary;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic [VAL_W-1:0]      pending_q, pending_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NIBBLE_W-1:0]   digit_q, digit_d;
    logic                  blank_q, blank_d;
    logic                  frame_q, frame_d;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  run_zero;

    clk_tick_div #(.DIV(REFRESH_DIV)) u_div (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .tick_o (tick)
    );

    assign boundary = tick && (slot_q == LAST_SLOT);

    always_comb begin
        slot_d = slot_q;
        if (tick) slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end

    // A LOAD landing on the boundary bypasses pending so the newest value wins.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            if (LOAD)            active_d = VALUE;
            else if (pend_vld_q) active_d = pending_q;
            pend_vld_d = 1'b0;
        end else if (LOAD) begin
            pending_d  = VALUE;
            pend_vld_d = 1'b1;
        end
    end

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the active value are all blank.
    always_comb begin
        upper_zero = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero && (active_q[NIBBLE_W*i +: NIBBLE_W] == BLANK_NIBBLE);
            upper_zero[i] = run_zero;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (slot_q != SLOT_W'(i));
        digit_d = active_q[NIBBLE_W*slot_q +: NIBBLE_W];
        blank_d = BLANK_LZ && (slot_q != '0) && upper_zero[slot_q];
        frame_d = boundary;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q     <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= AN_OFF[NUM_DIGITS-1:0];
            digit_q    <= '0;
            blank_q    <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            digit_q    <= digit_d;
            blank_q    <= blank_d;
            frame_q    <= frame_d;
        end
    end

    assign AN        = an_q;
    assign BI_DIGIT  = digit_q;
    assign DIG_BLANK = blank_q;
    assign FRAME     = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed + random bench for seg_scan_mux (4 digits, 4 clocks per slot) against
// a cycle-count based display model.
module tb_seg_scan_mux;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FR  = ND * DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LOAD = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [15:0] VALUE = '0;
    logic [3:0]  BI_DIGIT;
    logic        DIG_BLANK;
    logic [3:0]  AN;
    logic        FRAME;

    seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .LOAD      (LOAD),
        .VALUE     (VALUE),
        .BLANK_LZ  (BLANK_LZ),
        .BI_DIGIT  (BI_DIGIT),
        .DIG_BLANK (DIG_BLANK),
        .AN        (AN),
        .FRAME     (FRAME)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    int          k;          // clock edges since reset release
    logic [15:0] m_act;      // value shown in the current frame
    logic [15:0] m_pend;
    bit          m_nv;
    bit          blz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"},    AN,        16'hF);
        chk({tag, "_dig"},   BI_DIGIT,  16'h0);
        chk({tag, "_blank"}, DIG_BLANK, 16'h1);
        chk({tag, "_frame"}, FRAME,     16'h0);
    endtask

    // One clock: outputs after edge k+1 show the slot/value of the cycle before it.
    task automatic step(input bit ld, input logic [15:0] v);
        int         s;
        logic [3:0] e_an;
        logic [3:0] e_dig;
        bit         e_blank;
        bit         bnd;
        LOAD     = ld;
        VALUE    = v;
        BLANK_LZ = blz;
        s        = (k / DIV) % ND;
        e_an     = ~(4'b0001 << s);
        e_dig    = 4'((m_act >> (4 * s)) & 16'hF);
        e_blank  = blz && (s != 0) && ((m_act >> (4 * s)) == 16'h0);
        bnd      = ((k + 1) % FR) == 0;
        @(posedge CLK);
        #1;
        chk("an",    AN,        e_an);
        chk("digit", BI_DIGIT,  e_dig);
        chk("blank", DIG_BLANK, e_blank);
        chk("frame", FRAME,     bnd);
        if (bnd) begin
            if (ld)        m_act = v;
            else if (m_nv) m_act = m_pend;
            m_nv = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_nv   = 1'b1;
        end
        k++;
        LOAD = 1'b0;
    endtask

    initial begin
        bit          ld;
        logic [15:0] v;
        k = 0; m_act = '0; m_pend = '0; m_nv = 1'b0; blz = 1'b0;

        // Reset held, then released away from the edge.
        #12;
        chk_reset("rst_hold");
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (36) step(1'b0, 16'h0);

        // Mid-frame load: current frame keeps the old value.
        repeat (2) step(1'b0, 16'h0);
        step(1'b1, 16'h1A3F);
        repeat (30) step(1'b0, 16'h0);

        // Leading-zero blanking.
        blz = 1'b1;
        step(1'b1, 16'h0070);
        repeat (32) step(1'b0, 16'h0);
        step(1'b1, 16'h0000);
        repeat (32) step(1'b0, 16'h0);
        blz = 1'b0;
        repeat (6) step(1'b0, 16'h0);
        blz = 1'b1;

        // Last load in a frame wins; a load on the boundary shows next frame.
        while ((k % FR) != 2) step(1'b0, 16'h0);
        step(1'b1, 16'h1111);
        repeat (3) step(1'b0, 16'h0);
        step(1'b1, 16'h2222);
        while (((k + 1) % FR) != 0) step(1'b0, 16'h0);
        step(1'b1, 16'h3333);
        repeat (20) step(1'b0, 16'h0);

        // Random loads, values with variable leading-zero runs, BLANK_LZ toggles.
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) blz = ~blz;
            step(ld, v);
        end

        // Asynchronous reset at slot 2 with a pending value.
        while (((k / DIV) % ND) != 2 || (k % DIV) != 0) step(1'b0, 16'h0);
        step(1'b1, 16'hBEEF);
        step(1'b0, 16'h0);
        RST_N = 1'b0;
        #1;
        chk_reset("rst_async");
        @(posedge CLK);
        #1;
        chk_reset("rst_edge");
        @(negedge CLK);
        RST_N = 1'b1;
        k = 0; m_act = '0; m_pend = '0; m_nv = 1'b0;
        repeat (40) step(1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
